// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator opcodes, button-code type and player FSM encoding
package calc_pkg;

    localparam logic [3:0] OP_CODE0 = 4'b0000;
    localparam logic [3:0] OP_CODE1 = 4'b0001;
    localparam logic [3:0] OP_CODE2 = 4'b0100;
    localparam logic [3:0] OP_CODE3 = 4'b0101;
    localparam logic [3:0] OP_CODE4 = 4'b0110;
    localparam logic [3:0] OP_CODE5 = 4'b1010;
    localparam logic [3:0] OP_CODE6 = 4'b1011;
    localparam logic [3:0] OP_CODE7 = 4'b1100;

    // {btnl, btnr, btnd}
    typedef logic [2:0] btn_code_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_PRESS   = 2'd2,
        ST_RELEASE = 2'd3
    } btn_state_t;

endpackage

// File: rtl/calc_op_dec.sv
// rtl/calc_op_dec.sv - maps an ALU opcode to the button code that produces it
import calc_pkg::*;

module calc_op_dec (
    input  logic [3:0] op_in,
    output btn_code_t  code,
    output logic       legal
);

    always_comb begin
        code  = 3'b000;
        legal = 1'b1;
        case (op_in)
            OP_CODE0: code = 3'b000;
            OP_CODE1: code = 3'b001;
            OP_CODE2: code = 3'b010;
            OP_CODE3: code = 3'b011;
            OP_CODE4: code = 3'b100;
            OP_CODE5: code = 3'b101;
            OP_CODE6: code = 3'b110;
            OP_CODE7: code = 3'b111;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/calc_btn_player.sv
// rtl/calc_btn_player.sv - replays an opcode as a timed select/press/release button sequence
import calc_pkg::*;

module calc_btn_player #(
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned PRESS_CYC   = 8,
    parameter int unsigned RELEASE_CYC = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       op_valid,
    input  logic [3:0] op_in,
    output logic       op_ready,
    output logic       btnl,
    output logic       btnr,
    output logic       btnd,
    output logic       btnc,
    output logic       busy,
    output logic       done,
    output logic       err_invalid
);

    if (SETUP_CYC < 1 || SETUP_CYC > 255) begin : g_bad_setup
        $error("calc_btn_player: SETUP_CYC must be 1..255");
    end
    if (PRESS_CYC < 1 || PRESS_CYC > 255) begin : g_bad_press
        $error("calc_btn_player: PRESS_CYC must be 1..255");
    end
    if (RELEASE_CYC < 1 || RELEASE_CYC > 255) begin : g_bad_release
        $error("calc_btn_player: RELEASE_CYC must be 1..255");
    end

    localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PRESS_LD   = 8'(PRESS_CYC - 1);
    localparam logic [7:0] RELEASE_LD = 8'(RELEASE_CYC - 1);

    btn_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    btn_code_t  btn_q, btn_d;
    logic       btnc_q, btnc_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    btn_code_t  dec_code;
    logic       dec_legal;

    calc_op_dec u_dec (
        .op_in (op_in),
        .code  (dec_code),
        .legal (dec_legal)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            btn_q   <= 3'b000;
            btnc_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
            btnc_q  <= btnc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Button levels are computed one cycle ahead so every output leaves a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        btn_d   = btn_q;
        btnc_d  = btnc_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    if (dec_legal) begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                        btn_d   = dec_code;
                        btnc_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_PRESS;
                    cnt_d   = PRESS_LD;
                    btnc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_PRESS: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_RELEASE;
                    cnt_d   = RELEASE_LD;
                    btnc_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    btn_d   = 3'b000;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                btn_d   = 3'b000;
                btnc_d  = 1'b0;
            end
        endcase
    end

    assign op_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign btnl        = btn_q[2];
    assign btnr        = btn_q[1];
    assign btnd        = btn_q[0];
    assign btnc        = btnc_q;
    assign done        = done_q;
    assign err_invalid = err_q;

endmodule

// File: tb/tb_calc_btn_player.sv
// tb/tb_calc_btn_player.sv - randomized self-checking bench for calc_btn_player
`timescale 1ns/1ps

module tb_calc_btn_player;

    localparam int S = 4;
    localparam int P = 8;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       op_valid = 1'b0;
    logic [3:0] op_in = 4'd0;
    logic       op_ready, btnl, btnr, btnd, btnc, busy, done, err_invalid;

    logic       op_valid2 = 1'b0;
    logic [3:0] op_in2 = 4'd0;
    logic       op_ready2, btnl2, btnr2, btnd2, btnc2, busy2, done2, err2;

    int n_tests = 0;
    int n_fail  = 0;

    // index = button code {btnl,btnr,btnd}, value = opcode the encoder produces
    logic [3:0] legal_ops [8] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101,
                                  4'b0110, 4'b1010, 4'b1011, 4'b1100};

    logic [2:0] prev_btns = 3'b000;
    logic       prev_btnc = 1'b0;

    always #5 clk = ~clk;

    calc_btn_player dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_in(op_in),
        .op_ready(op_ready), .btnl(btnl), .btnr(btnr), .btnd(btnd), .btnc(btnc),
        .busy(busy), .done(done), .err_invalid(err_invalid)
    );

    calc_btn_player #(.SETUP_CYC(1), .PRESS_CYC(1), .RELEASE_CYC(1)) dut_min (
        .clk(clk), .resetn(resetn), .op_valid(op_valid2), .op_in(op_in2),
        .op_ready(op_ready2), .btnl(btnl2), .btnr(btnr2), .btnd(btnd2), .btnc(btnc2),
        .busy(busy2), .done(done2), .err_invalid(err2)
    );

    // {op_ready, busy, btnl, btnr, btnd, btnc, done, err_invalid}
    function automatic logic [7:0] obs();
        return {op_ready, busy, btnl, btnr, btnd, btnc, done, err_invalid};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int code_of(input logic [3:0] op);
        int c = -1;
        for (int i = 0; i < 8; i++) if (legal_ops[i] == op) c = i;
        return c;
    endfunction

    // Offers op on the next edge and checks the whole response, ending on the done cycle.
    task automatic check_seq(input logic [3:0] op, input bit hold, input string tag);
        int         c;
        logic [2:0] cb;
        logic [7:0] exp;
        logic       exp_c;
        c = code_of(op);
        op_valid = 1'b1;
        op_in    = op;
        step();
        if (!hold) op_valid = 1'b0;
        if (c < 0) begin
            exp = 8'b1000_0001;
            n_tests++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL %s illegal op %b: got %b want %b", tag, op, obs(), exp);
            end
            return;
        end
        cb = 3'(c);
        for (int k = 1; k <= S + P + R; k++) begin
            exp_c = (k > S) && (k <= S + P);
            exp   = {1'b0, 1'b1, cb, exp_c, 1'b0, 1'b0};
            n_tests++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL %s op %b cycle %0d: got %b want %b", tag, op, k, obs(), exp);
            end
            if (btnc) begin
                n_tests++;
                if (legal_ops[{btnl, btnr, btnd}] !== op) begin
                    n_fail++;
                    $display("FAIL %s encode cycle %0d: got %b want %b", tag, k,
                             legal_ops[{btnl, btnr, btnd}], op);
                end
            end
            if ({btnl, btnr, btnd} != prev_btns && (btnc || prev_btnc)) begin
                n_fail++;
                $display("FAIL %s select changed with btnc high: got %b want %b", tag,
                         {btnl, btnr, btnd}, prev_btns);
            end
            prev_btns = {btnl, btnr, btnd};
            prev_btnc = btnc;
            if (hold) op_in = 4'($urandom_range(0, 15));
            step();
        end
        exp = 8'b1000_0010;
        n_tests++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL %s done cycle op %b: got %b want %b", tag, op, obs(), exp);
        end
        prev_btns = {btnl, btnr, btnd};
        prev_btnc = btnc;
    endtask

    task automatic check_idle(input string tag);
        n_tests++;
        if (obs() !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL %s idle: got %b want %b", tag, obs(), 8'b1000_0000);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        check_idle("reset");
        n_tests++;
        if ({op_ready2, busy2, btnl2, btnr2, btnd2, btnc2, done2, err2} !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL reset_min: got %b want %b",
                     {op_ready2, busy2, btnl2, btnr2, btnd2, btnc2, done2, err2}, 8'b1000_0000);
        end
        step();
        resetn = 1'b1;
        step();
        check_idle("after_reset");
    endtask

    task automatic test_basic();
        check_seq(4'b0110, 1'b0, "basic");
        step();
        check_idle("basic_after");
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            check_seq(4'(i), 1'b0, "sweep");
            step();
            check_idle("sweep_after");
        end
    endtask

    task automatic test_hold_valid();
        check_seq(4'b0101, 1'b1, "hold_first");
        check_seq(4'b1010, 1'b0, "hold_second");
        step();
        check_idle("hold_after");
    endtask

    task automatic test_back_to_back();
        check_seq(4'b0001, 1'b1, "b2b_first");
        check_seq(4'b1011, 1'b1, "b2b_second");
        op_valid = 1'b0;
        step();
        check_idle("b2b_after");
        op_valid = 1'b1;
        check_seq(4'b0111, 1'b1, "b2b_bad1");
        check_seq(4'b1111, 1'b1, "b2b_bad2");
        op_valid = 1'b0;
        step();
        check_idle("b2b_bad_after");
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1;
        op_in    = 4'b0101;
        step();
        op_valid = 1'b0;
        repeat (6) step();
        n_tests++;
        if (btnc !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid precondition btnc: got %b want %b", btnc, 1'b1);
        end
        resetn = 1'b0;
        #1;
        check_idle("reset_mid_same_cycle");
        step();
        resetn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check_idle("reset_mid_no_done");
        end
        prev_btns = 3'b000;
        prev_btnc = 1'b0;
    endtask

    task automatic test_min_params();
        logic [7:0] o, e;
        op_valid2 = 1'b1;
        op_in2    = 4'b1100;
        step();
        op_valid2 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            o = {op_ready2, busy2, btnl2, btnr2, btnd2, btnc2, done2, err2};
            if (k == 4) e = 8'b1000_0010;
            else e = {2'b01, 3'b111, (k == 2), 2'b00};
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL min_params cycle %0d: got %b want %b", k, o, e);
            end
            step();
        end
    endtask

    task automatic test_random();
        int gap;
        for (int n = 0; n < 12; n++) begin
            check_seq(4'($urandom_range(0, 15)), 1'b0, "random");
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                step();
                check_idle("random_gap");
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_hold_valid();
        test_back_to_back();
        test_reset_mid();
        test_min_params();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_btn_player.md
Name: calc_btn_player

Overview:
Drives the calculator's button lines from an opcode stream, in the opposite direction to the button-to-opcode encoder. It accepts a 4-bit ALU opcode over a valid/ready handshake and maps it back to the (btnl, btnr, btnd) combination that the encoder turns into that opcode. It then plays a timed press sequence: the operand-select buttons settle, btnc strobes, and everything releases. It sits between the scripted-command/self-test source and the calculator top, in place of the physical buttons.

Parameters:
SETUP_CYC, 4, cycles btnl/btnr/btnd are held stable before btnc asserts (legal range 1..255)
PRESS_CYC, 8, cycles btnc is held high (legal range 1..255)
RELEASE_CYC, 4, cycles btnl/btnr/btnd stay held after btnc drops (legal range 1..255)

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous, active-low reset
op_valid  input  1  source presents an opcode
op_in  input  4  ALU opcode to replay
op_ready  output  1  block can accept an opcode (high only in IDLE)
btnl  output  1  left button level
btnr  output  1  right button level
btnd  output  1  down button level
btnc  output  1  centre/execute button level
busy  output  1  press sequence in progress
done  output  1  one-cycle pulse when a sequence completes
err_invalid  output  1  one-cycle pulse when an accepted opcode has no button encoding

Behaviour:
- Reset (resetn=0, async): state=IDLE, all counters 0.
  - btnl/btnr/btnd/btnc/busy/done/err_invalid = 0.
  - op_ready = 1 (decoded from IDLE).
- Reset mid-sequence drops every button line in the same cycle. No done pulse. The sequence is lost.
- Decode table, opcode -> {btnl,btnr,btnd}:
  - 0000->000, 0001->001, 0100->010, 0101->011
  - 0110->100, 1010->101, 1011->110, 1100->111
  - Every other opcode is invalid.
- Acceptance: transfer occurs on a rising edge with op_valid && op_ready. op_in is registered at that edge. op_in is ignored while op_ready=0.
- FSM states: IDLE, SETUP, PRESS, RELEASE.
- IDLE:
  - On a valid-opcode transfer, go to SETUP.
  - On an invalid transfer, stay in IDLE and pulse err_invalid for exactly 1 cycle (the cycle after the edge). Buttons are untouched, op_ready stays 1.
  - Back-to-back invalid opcodes give one err pulse each.
- SETUP: lasts SETUP_CYC cycles. Decoded btnl/btnr/btnd are driven; btnc=0, busy=1.
- PRESS: lasts PRESS_CYC cycles. Buttons are held and btnc=1.
- RELEASE: lasts RELEASE_CYC cycles. btnc=0, buttons still held.
- Exit from RELEASE:
  - Go to IDLE.
  - btnl/btnr/btnd return to 0.
  - done=1 for that first IDLE cycle, with op_ready=1 in the same cycle.
- Latency:
  - First button change is 1 cycle after the accept edge.
  - Total busy time is SETUP_CYC+PRESS_CYC+RELEASE_CYC cycles.
  - Next accept is possible on the edge ending the done cycle. Minimum opcode spacing is busy time + 1 cycle.
- Button lines change only on state entry and are glitch-free (registered outputs). btnc never rises in the same cycle the select buttons change.
- Opcode 0000 (code 000) still plays a full sequence: only btnc toggles.
- Counter: one shared down-counter, 8 bits, reloaded with (parameter-1) on each state entry. The state advances when it reaches 0.
- Parameter value 0 is illegal. An elaboration-time check fails the build.

Decomposition:
- Shared calc package holds:
  - opcode localparams (the eight legal codes),
  - the 3-bit button-code typedef,
  - the FSM state encoding, which is also used by the encoder bench.
- One combinational sub-module, calc_op_dec: op_in[3:0] -> {code[2:0], legal}. It is reused by the bench scoreboard to cross-check the encoder.

Test Plan:
- Reset then op_in=0110, op_valid=1 (defaults):
  - op_ready drops next cycle.
  - btnl=1, btnr=0, btnd=0 for 4 cycles, then btnc=1 for 8 cycles, then 4 release cycles.
  - Then all 0, done=1 for 1 cycle; busy high for exactly 16 cycles.
- Sweep all 16 opcodes, with the calc_enc output tied back from btnl/btnr/btnd:
  - For the 8 legal codes, the encoder's alu_op equals op_in while btnc=1.
  - The 8 illegal codes give exactly one err_invalid pulse each, no button activity, and op_ready never drops.
- Hold op_valid=1 with changing op_in during a sequence: only the first opcode is replayed and the buttons stay constant. The second opcode is accepted on the done-cycle edge.
- Assert resetn=0 during PRESS (cycle 7): btnc and all buttons are 0 in the same cycle, op_ready=1, and no done pulse follows.
- Parameters SETUP=1, PRESS=1, RELEASE=1 with op 1100: btnl=btnr=btnd=1 for 3 cycles, btnc high for exactly cycle 2, done on cycle 4.
- Back-to-back legal opcodes 0001 then 1011, op_valid held high: the second sequence starts exactly 1 cycle after done, and btnd changes only when btnc=0.
